axi_read_master_arbiter: RTL

Shares the single AXI read-address/read-data path of the bus between `NUM_M` read masters (instruction fetch, data access, DMA). It grants one AR request at a time using round-robin priority, forwards it to the slave-side interconnect, and holds the grant until the last R beat handshakes. It sits upstream of the slave-side read arbiter/decoder in the AXI bridge. It also checks the beat count against ARLEN.

---
 rtl/axi_read_master_arbiter_pkg.sv | 23 ++
 rtl/axi_read_master_arbiter_rr_picker.sv | 38 +++
 rtl/axi_read_master_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/axi_read_master_arbiter_pkg.sv
// Shared types for the AXI read-master arbiter.
//   arb_state_e : arbiter FSM states (IDLE / ADDR / DATA)
//   AXI_*_W     : default field widths of a captured AR request
//   ar_req_t    : captured AR request {addr, id, len}
package axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_LEN_W-1:0]  len;
    } ar_req_t;

endpackage

// File: rtl/axi_read_master_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req    : request vector, one bit per master
//   ptr    : highest-priority index for this pick
//   found  : at least one request is present
//   idx    : index of the winner (first requester at or after ptr, wrapping)
//   onehot : one-hot form of idx, zero when nothing is requested
module rr_picker #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    int               cand;
    logic [IDX_W-1:0] cand_w;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = 0;
        cand_w = '0;
        for (int k = 0; k < N; k++) begin
            cand   = (int'(ptr) + k) % N;
            cand_w = IDX_W'(cand);
            if (!found && req[cand_w]) begin
                found          = 1'b1;
                idx            = cand_w;
                onehot[cand_w] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_read_master_arbiter.sv
// AXI read-master arbiter: shares one AR/R path between NUM_M masters.
// One AR request is granted at a time (round robin), forwarded to the
// interconnect, and the grant is held until the last R beat handshakes.
// The R beat count is checked against the captured ARLEN.
//   ACLK, ARESETn           : clock, asynchronous active-low reset
//   m_arvalid/araddr/arid/arlen, m_arready : packed per-master AR channel
//   s_arvalid/araddr/arid/arlen, s_arready : AR channel to the interconnect
//                             (s_arid = {granted index, master ARID})
//   rvalid, rready, rlast   : R handshake, observed only
//   grant                   : one-hot owner of the read path, zero when idle
//   busy                    : a transaction is in flight
//   len_err                 : one-cycle pulse on a beat/ARLEN mismatch
module axi_read_master_arbiter
    import axi_pkg::*;
#(
    parameter int NUM_M  = 3,
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int ID_W   = AXI_ID_W,
    parameter int LEN_W  = AXI_LEN_W,
    localparam int IDX_W = $clog2(NUM_M)
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [NUM_M-1:0]        m_arvalid,
    input  logic [NUM_M*ADDR_W-1:0] m_araddr,
    input  logic [NUM_M*ID_W-1:0]   m_arid,
    input  logic [NUM_M*LEN_W-1:0]  m_arlen,
    output logic [NUM_M-1:0]        m_arready,
    output logic                    s_arvalid,
    output logic [ADDR_W-1:0]       s_araddr,
    output logic [IDX_W+ID_W-1:0]   s_arid,
    output logic [LEN_W-1:0]        s_arlen,
    input  logic                    s_arready,
    input  logic                    rvalid,
    input  logic                    rready,
    input  logic                    rlast,
    output logic [NUM_M-1:0]        grant,
    output logic                    busy,
    output logic                    len_err
);

    // The captured request uses the package struct, so the field widths
    // must agree with it.
    if (ADDR_W != AXI_ADDR_W || ID_W != AXI_ID_W || LEN_W != AXI_LEN_W ||
        NUM_M < 2 || NUM_M > 4) begin : g_bad_params
        $error("axi_read_master_arbiter: unsupported parameter set");
    end

    arb_state_e        state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  idx_q;
    logic [NUM_M-1:0]  grant_q;
    ar_req_t           req_q;
    logic [LEN_W-1:0]  beat_cnt;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [NUM_M-1:0]  pick_onehot;

    rr_picker #(
        .N     (NUM_M),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (m_arvalid),
        .ptr    (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        s_arvalid = 1'b0;
        m_arready = '0;
        len_err   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) state_nxt = ADDR;
            end
            ADDR: begin
                s_arvalid = 1'b1;
                // Only the owner sees ARREADY, passed straight through.
                if (s_arready) begin
                    m_arready = grant_q;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                // beat_cnt holds the number of beats already accepted, so the
                // final beat is expected exactly when it equals ARLEN.
                if (rvalid && rready) begin
                    if (rlast) begin
                        state_nxt = IDLE;
                        len_err   = (beat_cnt != req_q.len);
                    end else begin
                        len_err   = (beat_cnt == req_q.len);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            idx_q    <= '0;
            grant_q  <= '0;
            req_q    <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_q    <= pick_onehot;
                        idx_q      <= pick_idx;
                        req_q.addr <= m_araddr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        req_q.id   <= m_arid[int'(pick_idx)*ID_W +: ID_W];
                        req_q.len  <= m_arlen[int'(pick_idx)*LEN_W +: LEN_W];
                    end
                end
                ADDR: begin
                    // R beats seen here cannot belong to this burst; the
                    // counter starts fresh once the address is accepted.
                    if (s_arready) begin
                        beat_cnt <= '0;
                        rr_ptr   <= (idx_q == IDX_W'(NUM_M - 1)) ? '0 : idx_q + 1'b1;
                    end
                end
                DATA: begin
                    if (rvalid && rready) begin
                        if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
                        if (rlast) grant_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant    = grant_q;
    assign busy     = (state != IDLE);
    assign s_araddr = req_q.addr;
    assign s_arid   = {idx_q, req_q.id};
    assign s_arlen  = req_q.len;

endmodule
